// File: rtl/mem_pkg.sv
// Shared types for the load/store unit: access-size encoding, FSM states
// and the alignment-fault rule used at request acceptance.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Size 11 is illegal; halves need even addresses, words need 4-byte alignment.
  function automatic logic is_fault(input logic [1:0] size, input logic [1:0] offset);
    logic fault;
    case (size)
      SZ_BYTE: fault = 1'b0;
      SZ_HALF: fault = offset[0];
      SZ_WORD: fault = (offset != 2'b00);
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response channel of the load/store unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);
  logic [7:0]  lane_bytes [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_bytes[gi] = rdata_raw[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = lane_bytes[offset];
  assign sel_half = offset[1] ? rdata_raw[31:16] : rdata_raw[15:0];

  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = 32'h0;
    rdata_ext   = 32'h0;
    case (size)
      SZ_BYTE: begin
        byte_en     = 4'b0001 << offset;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
      end
      SZ_HALF: begin
        byte_en     = offset[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{~is_unsigned & sel_half[15]}}, sel_half};
      end
      SZ_WORD: begin
        byte_en     = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = rdata_raw;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> RESP over a shared
// tristate RAM data bus; faulting requests skip straight to RESP.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [3:0]        mem_byte_en,
  inout  wire  [31:0]       mem_data
);
  state_e      state_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [1:0]  size_reg;
  logic        we_reg;
  logic        unsigned_reg;
  logic        rsp_valid_reg;
  logic        rsp_err_reg;
  logic [31:0] rsp_rdata_reg;

  logic        accept;
  logic        in_access;
  logic [3:0]  lane_en;
  logic [31:0] store_lanes;
  logic [31:0] load_ext;

  assign accept    = bus.req_valid && (state_reg == ST_IDLE);
  assign in_access = (state_reg == ST_ACCESS);

  mem_lane_align u_lane_align (
    .size        (size_reg),
    .offset      (addr_reg[1:0]),
    .is_unsigned (unsigned_reg),
    .wdata       (wdata_reg),
    .rdata_raw   (mem_data),
    .byte_en     (lane_en),
    .wdata_lanes (store_lanes),
    .rdata_ext   (load_ext)
  );

  // Bus outputs decode only from registers, so an async reset releases them at once.
  assign mem_addr    = in_access ? addr_reg[ADDR_W+1:2] : '0;
  assign mem_wen     = in_access & we_reg;
  assign mem_byte_en = in_access ? lane_en : 4'b0000;
  assign mem_data    = mem_wen ? store_lanes : {32{1'bz}};

  assign bus.req_ready = (state_reg == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= 32'h0;
      wdata_reg     <= 32'h0;
      size_reg      <= 2'b00;
      we_reg        <= 1'b0;
      unsigned_reg  <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= 32'h0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            addr_reg     <= bus.req_addr;
            wdata_reg    <= bus.req_wdata;
            size_reg     <= bus.req_size;
            we_reg       <= bus.req_we;
            unsigned_reg <= bus.req_unsigned;
            if (is_fault(bus.req_size, bus.req_addr[1:0])) begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= 32'h0;
            end else begin
              state_reg <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // Load lanes are sampled at the same edge the RAM commits a store.
          state_reg     <= ST_RESP;
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= we_reg ? 32'h0 : load_ext;
        end
        ST_RESP: begin
          state_reg     <= ST_IDLE;
          rsp_valid_reg <= 1'b0;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= 32'h0;
        end
        default: begin
          state_reg     <= ST_IDLE;
          rsp_valid_reg <= 1'b0;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a cycle-level expectation model
// and a small lane-addressable RAM on the shared data bus.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_byte_en;
  wire  [31:0] mem_data;

  mem_access_unit_if bus ();

  mem_access_unit #(.ADDR_W(30)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mem_addr    (mem_addr),
    .mem_wen     (mem_wen),
    .mem_byte_en (mem_byte_en),
    .mem_data    (mem_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: drives enabled lanes on reads, commits enabled lanes on writes.
  logic [31:0] ram [16];
  bit          ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'h01010101 * i;
      ram[1]    <= 32'hDEADBEEF;
      ram[2]    <= 32'hCAFEF00D;
      ram_ready <= 1'b1;
    end else if (mem_wen) begin
      for (int i = 0; i < 4; i++)
        if (mem_byte_en[i]) ram[mem_addr[3:0]][8*i +: 8] <= mem_data[8*i +: 8];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ram_drive
      assign mem_data[8*gi +: 8] = (!mem_wen && mem_byte_en[gi]) ? ram[mem_addr[3:0]][8*gi +: 8] : 8'bz;
    end
  endgenerate

  // ---------------- model ----------------
  typedef struct {
    int          cyc;
    logic [29:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] data;
  } bus_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_exp_t;

  bus_exp_t    bus_q [$];
  rsp_exp_t    rsp_q [$];
  logic [31:0] model_ram [16];

  int n_tests = 0;
  int n_fail  = 0;

  int          rsp_count  = 0;
  int          be_cycles  = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err   = 1'b0;
  logic [3:0]  last_be    = 4'h0;
  logic        last_wen   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] size, input logic [1:0] off);
    int m;
    m = ((1 << nbytes(size)) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    int n;
    n = nbytes(size);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic uns);
    logic [31:0] v, mask;
    int n;
    n = nbytes(size);
    v = word >> (8 * off);
    if (n == 4) return v;
    mask = (32'h1 << (8 * n)) - 32'h1;
    v = v & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Per-cycle compare process: expected bus activity, response and ready.
  initial begin
    bus_exp_t eb;
    rsp_exp_t er;
    bit       has_bus, has_rsp;
    for (int i = 0; i < 16; i++) model_ram[i] = 32'h01010101 * i;
    model_ram[1] = 32'hDEADBEEF;
    model_ram[2] = 32'hCAFEF00D;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus_q.delete();
        rsp_q.delete();
      end else begin
        has_bus = 1'b0;
        has_rsp = 1'b0;
        eb = '{cyc: 0, addr: '0, we: 1'b0, be: 4'h0, data: 32'h0};
        er = '{cyc: 0, rdata: 32'h0, err: 1'b0};
        while (bus_q.size() > 0 && bus_q[0].cyc < cyc) begin
          check("bus_expect_missed", cyc, bus_q[0].cyc);
          void'(bus_q.pop_front());
        end
        while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
          check("rsp_expect_missed", cyc, rsp_q[0].cyc);
          void'(rsp_q.pop_front());
        end
        if (bus_q.size() > 0 && bus_q[0].cyc == cyc) begin
          eb = bus_q.pop_front();
          has_bus = 1'b1;
        end
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
          er = rsp_q.pop_front();
          has_rsp = 1'b1;
        end
        check("mem_byte_en", mem_byte_en, eb.be);
        check("mem_wen", mem_wen, eb.we);
        check("mem_addr", mem_addr, eb.addr);
        check("req_ready", bus.req_ready, !(has_bus || has_rsp));
        if (has_bus && eb.we) begin
          check("mem_data_store", mem_data, eb.data);
          for (int i = 0; i < 4; i++)
            if (eb.be[i]) model_ram[eb.addr[3:0]][8*i +: 8] = eb.data[8*i +: 8];
        end
        check("rsp_valid", bus.rsp_valid, has_rsp);
        if (has_rsp) begin
          check("rsp_rdata", bus.rsp_rdata, er.rdata);
          check("rsp_err", bus.rsp_err, er.err);
        end
        if (mem_byte_en != 4'h0) begin
          be_cycles++;
          last_be  = mem_byte_en;
          last_wen = mem_wen;
        end
        if (bus.rsp_valid) begin
          rsp_count++;
          last_rdata = bus.rsp_rdata;
          last_err   = bus.rsp_err;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output int acc_cyc);
    int  waited;
    bit  ok;
    bit  fault;
    logic [1:0] off;
    waited = 0;
    ok     = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    while (!ok && waited < 20) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready low for %0d cycles, required high", waited);
      acc_cyc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    off     = addr[1:0];
    fault   = (size == 2'b11) || ((off % nbytes(size)) != 0);
    if (fault) begin
      rsp_q.push_back('{cyc: acc_cyc, rdata: 32'h0, err: 1'b1});
    end else begin
      bus_q.push_back('{cyc: acc_cyc, addr: addr[31:2], we: we, be: exp_be(size, off),
                        data: we ? exp_lanes(size, wdata) : 32'h0});
      rsp_q.push_back('{cyc: acc_cyc + 1,
                        rdata: we ? 32'h0 : exp_load(model_ram[addr[5:2]], size, off, uns),
                        err: 1'b0});
    end
    $display("[TB] txn we=%0d size=%0d uns=%0d addr=%h wdata=%h accepted@%0d fault=%0d",
             we, size, uns, addr, wdata, acc_cyc, fault);
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_count < target && n < 12) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (rsp_count < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_timeout: saw %0d responses, required %0d", rsp_count, target);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int a;
    int start;
    start = rsp_count;
    issue(we, size, uns, addr, wdata, a);
    bus.req_valid = 1'b0;
    wait_rsp(start + 1);
  endtask

  initial begin
    int a1, a2, start, be_before;
    logic [31:0] saved_w2;

    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", bus.req_ready, 1'b1);
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset_rsp_err", bus.rsp_err, 1'b0);
    check("reset_mem_wen", mem_wen, 1'b0);
    check("reset_mem_byte_en", mem_byte_en, 4'h0);
    check("reset_mem_addr", mem_addr, 30'h0);
    rst_n = 1'b1;

    // Loads from word 1 = DEADBEEF
    do_req(1'b0, 2'b00, 1'b0, 32'h7, 32'h0);
    check("lb7_rdata", last_rdata, 32'hFFFFFFDE);
    check("lb7_be", last_be, 4'b1000);
    do_req(1'b0, 2'b00, 1'b1, 32'h7, 32'h0);
    check("lbu7_rdata", last_rdata, 32'h000000DE);
    do_req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
    check("lh6_rdata", last_rdata, 32'hFFFFDEAD);
    check("lh6_be", last_be, 4'b1100);
    do_req(1'b0, 2'b01, 1'b1, 32'h4, 32'h0);
    check("lhu4_rdata", last_rdata, 32'h0000BEEF);
    check("lhu4_be", last_be, 4'b0011);

    // Byte store into lane 1, then read the word back
    be_before = be_cycles;
    do_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h00000055);
    check("sb5_wen", last_wen, 1'b1);
    check("sb5_be", last_be, 4'b0010);
    check("sb5_be_cycles", be_cycles - be_before, 1);
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    check("lw4_rdata", last_rdata, 32'hDEAD55EF);

    // Faults: misaligned word, misaligned half, illegal size
    be_before = be_cycles;
    do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
    check("lw6_err", last_err, 1'b1);
    check("lw6_rdata", last_rdata, 32'h0);
    do_req(1'b0, 2'b01, 1'b0, 32'h5, 32'h0);
    check("lh5_err", last_err, 1'b1);
    do_req(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF);
    check("sz11_err", last_err, 1'b1);
    check("fault_no_bus", be_cycles - be_before, 0);

    // Half store into upper lanes of word 2 (CAFEF00D)
    do_req(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000ABCD);
    check("sh_be", last_be, 4'b1100);
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    check("lw8_rdata", last_rdata, 32'hABCDF00D);
    do_req(1'b0, 2'b00, 1'b0, 32'h8, 32'h0);
    check("lb8_rdata", last_rdata, 32'h0000000D);
    do_req(1'b0, 2'b00, 1'b0, 32'h9, 32'h0);
    check("lb9_rdata", last_rdata, 32'hFFFFFFF0);
    do_req(1'b0, 2'b00, 1'b1, 32'hB, 32'h0);
    check("lbuB_rdata", last_rdata, 32'h000000AB);

    // Back-to-back with req_valid held high
    start = rsp_count;
    issue(1'b1, 2'b10, 1'b0, 32'hC, 32'h11223344, a1);
    issue(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, a2);
    bus.req_valid = 1'b0;
    check("b2b_gap", a2 - a1, 3);
    wait_rsp(start + 2);
    check("b2b_lw_rdata", last_rdata, 32'h11223344);

    // Reset asserted mid-ACCESS of a word store
    saved_w2 = ram[2];
    issue(1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678, a1);
    bus.req_valid = 1'b0;
    #1;
    check("mid_access_wen", mem_wen, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wen", mem_wen, 1'b0);
    check("rst_mid_be", mem_byte_en, 4'h0);
    check("rst_mid_addr", mem_addr, 30'h0);
    check("rst_mid_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_mid_req_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_mid_ram_word2", ram[2], saved_w2);
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    check("post_rst_lw8", last_rdata, 32'hABCDF00D);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
